// File: rtl/sw_input_conditioner.sv
// Slide-switch conditioner: two-flop synchroniser, shared sample-tick prescaler, per-bit debounce.
// Optional build macro SW_STATUS_EN turns io_sw_o[31] into a registered "settling" flag.
module sw_input_conditioner #(
  parameter int NUM_SW     = 18,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_SW-1:0] sw_raw_i,
  output logic [31:0]       io_sw_o,
  output logic              sw_change_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_CNT + 1);

  logic [NUM_SW-1:0] r_meta;
  logic [NUM_SW-1:0] r_sync;
  logic [PW-1:0]     r_presc;
  logic [CW-1:0]     r_cnt [NUM_SW];
  logic [NUM_SW-1:0] r_sw;
  logic              r_change;

  logic              w_tick;
  logic [CW-1:0]     w_cnt_next [NUM_SW];
  logic [NUM_SW-1:0] w_sw_next;
  logic              w_status;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta  <= '0;
      r_sync  <= '0;
      r_presc <= '0;
    end else begin
      r_meta  <= sw_raw_i;
      r_sync  <= r_meta;
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  // A sample that matches the accepted level clears progress; STABLE_CNT
  // consecutive differing ticks are needed before the new level is taken.
  always_comb begin
    w_sw_next = r_sw;
    for (int i = 0; i < NUM_SW; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (w_tick) begin
        if (r_sync[i] == r_sw[i]) begin
          w_cnt_next[i] = '0;
        end else if (r_cnt[i] == CW'(STABLE_CNT - 1)) begin
          w_sw_next[i]  = r_sync[i];
          w_cnt_next[i] = '0;
        end else begin
          w_cnt_next[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_SW; i++) r_cnt[i] <= '0;
      r_sw     <= '0;
      r_change <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SW; i++) r_cnt[i] <= w_cnt_next[i];
      r_sw     <= w_sw_next;
      r_change <= (w_sw_next != r_sw);
    end
  end

`ifdef SW_STATUS_EN
  logic r_settling;
  logic w_any_cnt;

  always_comb begin
    w_any_cnt = 1'b0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (w_cnt_next[i] != '0) w_any_cnt = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_settling <= 1'b0;
    else         r_settling <= w_any_cnt;
  end

  assign w_status = r_settling;
`else
  assign w_status = 1'b0;
`endif

  always_comb begin
    io_sw_o             = '0;
    io_sw_o[NUM_SW-1:0] = r_sw;
    io_sw_o[31]         = w_status;
  end

  assign sw_change_o = r_change;

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Scoreboard bench for sw_input_conditioner: stimulus queues expected words with
// an accept-cycle window, a monitor pops and checks on each sw_change_o pulse.
module tb_sw_input_conditioner;

  localparam int NUM_SW = 18;
  localparam int TICK_DIV = 4;
  localparam int STABLE_CNT = 3;
`ifdef SW_STATUS_EN
  localparam logic [31:0] MASK = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] MASK = 32'hFFFF_FFFF;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NUM_SW-1:0] sw_raw_i = '0;
  logic [31:0]       io_sw_o;
  logic              sw_change_o;

  sw_input_conditioner #(
    .NUM_SW(NUM_SW), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sw_raw_i(sw_raw_i),
    .io_sw_o(io_sw_o), .sw_change_o(sw_change_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] val;
    int          lo;
    int          hi;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] prev = '0;

  always @(posedge clk_i) begin
    logic chg;
    exp_t e;
    #1;
    cyc++;
    if (!rst_ni) begin
      prev = io_sw_o;
    end else begin
      chg = ((io_sw_o & MASK) != (prev & MASK));
      if (sw_change_o || chg) begin
        n_tests++;
        if (sw_change_o != chg) begin
          n_fail++;
          $display("FAIL strobe_vs_word cyc=%0d: sw_change_o=%0b word_changed=%0b", cyc, sw_change_o, chg);
        end
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d: io_sw_o=%h, no change required", cyc, io_sw_o);
        end else begin
          e = q.pop_front();
          if ((io_sw_o & MASK) != e.val || cyc < e.lo || cyc > e.hi) begin
            n_fail++;
            $display("FAIL %s: got io_sw_o=%h at cyc %0d, required %h in cyc %0d..%0d",
                     e.name, io_sw_o, cyc, e.val, e.lo, e.hi);
          end
        end
      end else if (q.size() > 0 && cyc > q[0].hi) begin
        e = q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL %s_timeout: got io_sw_o=%h with no pulse by cyc %0d, required %h",
                 e.name, io_sw_o, e.hi, e.val);
      end
      prev = io_sw_o;
    end
  end

  task automatic expect_word(input string name, input int lo_off, input int hi_off);
    exp_t e;
    e.val  = 32'(sw_raw_i);
    e.lo   = cyc + lo_off;
    e.hi   = cyc + hi_off;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() > 0; k++) @(negedge clk_i);
    repeat (4) @(negedge clk_i);
  endtask

  initial begin
    // reset with all switches high
    sw_raw_i = 18'h3FFFF;
    rst_ni   = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_word", io_sw_o, 32'h0);
    check("reset_strobe", {31'h0, sw_change_o}, 32'h0);
    rst_ni = 1'b1;
    expect_word("reset_release_accept", 11, 14);
    drain();

    sw_raw_i = '0;
    expect_word("all_low", 11, 14);
    drain();

    // clean step on bit 0
    sw_raw_i[0] = 1'b1;
    expect_word("clean_step_b0", 11, 14);
    drain();

    // 6-cycle glitch on bit 5 must be rejected
    sw_raw_i[5] = 1'b1;
    repeat (6) @(negedge clk_i);
    sw_raw_i[5] = 1'b0;
    repeat (40) @(negedge clk_i);
    check("glitch_b5", {31'h0, io_sw_o[5]}, 32'h0);

    // bounce on bit 3, then hold high
    for (int i = 0; i < 10; i++) begin
      sw_raw_i[3] = ~sw_raw_i[3];
      repeat (3) @(negedge clk_i);
    end
    check("bounce_b3_low", {31'h0, io_sw_o[3]}, 32'h0);
    sw_raw_i[3] = 1'b1;
    expect_word("bounce_hold_b3", 1, 14);
    drain();

    // simultaneous fall on bit 2 and rise on bit 7
    sw_raw_i[2] = 1'b1;
    expect_word("set_b2", 11, 14);
    drain();
    sw_raw_i[2] = 1'b0;
    sw_raw_i[7] = 1'b1;
    expect_word("simul_b2_fall_b7_rise", 11, 14);
    drain();
    check("simul_word", io_sw_o & MASK, 32'h0000_0089);

    // reset in the middle of a step on bit 9
    sw_raw_i[9] = 1'b1;
    repeat (8) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("midreset_word_async", io_sw_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check("midreset_word_release", io_sw_o, 32'h0);
    expect_word("midreset_reaccept", 11, 14);
    drain();
    check("final_word", io_sw_o & MASK, 32'h0000_0289);

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
